rand_stream_checker: RTL and testbench

//  Receiving end of the BuildingDrops serial pseudo-random bit stream. Self-synchronises to the
//  16-bit LFSR sequence (b[k+16] = b[k]^b[k+2]^b[k+3]^b[k+5]), then predicts every following bit
//  and flags mismatches. Used on the board/bench to prove the random source driving block spawns is

---
 rtl/rand_stream_checker.sv | 114 +++++++++++
 tb/tb_rand_stream_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rand_stream_checker.sv
// Self-synchronising checker for the 16-bit LFSR bit stream (b[k+16]=b[k]^b[k+2]^b[k+3]^b[k+5]).
// Latency 1 clk from accepted sample to locked/err_pulse; no backpressure, rx_valid=0 simply idles.
// Optional accepted-bit counter port bit_count when RAND_CHECKER_BITCNT_EN is defined.
module rand_stream_checker #(
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
`ifdef RAND_CHECKER_BITCNT_EN
  output logic [31:0]      bit_count,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam int ERR_W = $clog2(LOSS_THRESH + 1);

  typedef enum logic {SEED, CHECK} state_t;

  state_t           state;
  logic [15:0]      window;
  logic [3:0]       fill;
  logic [WIN_W-1:0] win_cnt;
  logic [ERR_W-1:0] win_err;

  logic             pred;
  logic [15:0]      win_nxt;
  logic             mismatch;
  logic             win_wrap;
  logic [ERR_W-1:0] win_err_inc;
  logic             loss;

  // Prediction uses the window before the new bit is shifted in.
  always_comb begin
    pred        = window[0] ^ window[2] ^ window[3] ^ window[5];
    win_nxt     = {rx_bit, window[15:1]};
    mismatch    = rx_valid && (state == CHECK) && (rx_bit != pred);
    win_wrap    = (win_cnt == WIN_W'(WIN_LEN - 1));
    win_err_inc = win_err + ERR_W'(mismatch);
    loss        = rx_valid && (state == CHECK) &&
                  ((mismatch && (win_err_inc == ERR_W'(LOSS_THRESH))) || (win_nxt == 16'd0));
  end

  assign locked = (state == CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      window    <= '0;
      fill      <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= mismatch;
      // A clear wins over an error arriving in the same cycle.
      if (clr)
        err_count <= '0;
      else if (mismatch && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_W'(1);

      if (rx_valid) begin
        window <= win_nxt;
        case (state)
          SEED: begin
            if (fill == 4'd15) begin
              fill <= '0;
              // All-zero is the LFSR lock-up state, so it can never seed a valid lock.
              if (win_nxt != 16'd0) begin
                state   <= CHECK;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              fill <= fill + 4'd1;
            end
          end
          CHECK: begin
            if (loss) begin
              state   <= SEED;
              fill    <= '0;
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);
              win_err <= win_wrap ? '0 : win_err_inc;
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end

`ifdef RAND_CHECKER_BITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_count <= '0;
    else if (clr)
      bit_count <= '0;
    else if (rx_valid && (state == CHECK))
      bit_count <= bit_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rand_stream_checker.sv
// Scoreboard bench: stimulus pushes expected locked/err_pulse/err_count per driven cycle,
// a monitor pops and compares one clock later.
module tb_rand_stream_checker;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_bit = 1'b0;
  logic             rx_valid = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
`ifdef RAND_CHECKER_BITCNT_EN
  logic [31:0]      bit_count;
`endif

  rand_stream_checker #(.WIN_LEN(64), .LOSS_THRESH(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
`ifdef RAND_CHECKER_BITCNT_EN
    .bit_count (bit_count),
`endif
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic             lk;
    logic             pl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // Monitor: outputs for a cycle's inputs are visible after the following posedge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        chk("locked", 32'(locked), 32'(mon_e.lk));
        chk("err_pulse", 32'(err_pulse), 32'(mon_e.pl));
        chk("err_count", 32'(err_count), 32'(mon_e.cnt));
      end
    end
  end

  // Expectation state, updated by hand-derived rules in the stimulus tasks.
  logic [15:0]      g;
  int               seed_cnt;
  logic             exp_lk;
  int               nerr;
  logic [CNT_W-1:0] exp_cnt;

  task automatic drive(input logic b, input logic v, input logic c, input logic pl);
    exp_t e;
    @(posedge clk);
    #1;
    rx_bit   = b;
    rx_valid = v;
    clr      = c;
    e.cyc = cyc;
    e.lk  = exp_lk;
    e.pl  = pl;
    e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic gen_next(output logic b);
    b = g[0];
    g = {g[0] ^ g[2] ^ g[3] ^ g[5], g[15:1]};
  endtask

  // Generator stream with optional single flipped bit; a flip costs errors at offsets 0,11,13,14.
  task automatic stream(input int n, input int flip_at, input int clr_at, input bit alt);
    logic b;
    logic pl;
    int   d;
    for (int i = 0; i < n; i++) begin
      gen_next(b);
      pl = 1'b0;
      if (i == flip_at) b = ~b;
      if (!exp_lk) begin
        seed_cnt++;
        if (seed_cnt == 16) begin
          exp_lk   = 1'b1;
          seed_cnt = 0;
        end
      end else begin
        d = i - flip_at;
        if (flip_at >= 0 && (d == 0 || d == 11 || d == 13 || d == 14)) begin
          pl = 1'b1;
          nerr++;
          if (nerr == 4) begin
            exp_lk = 1'b0;
            nerr   = 0;
          end
        end
      end
      if (i == clr_at) exp_cnt = '0;
      else if (pl && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      drive(b, 1'b1, (i == clr_at), pl);
      if (alt) drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted and released away from clock edges.
  task automatic reset_dut(input bit regen);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    clr      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #3;
    chk("rst_hold_locked", 32'(locked), 32'd0);
    rst_n    = 1'b1;
    exp_lk   = 1'b0;
    seed_cnt = 0;
    nerr     = 0;
    exp_cnt  = '0;
    if (regen) g = 16'h68F3;
  endtask

  initial begin
    g        = 16'h68F3;
    exp_lk   = 1'b0;
    seed_cnt = 0;
    nerr     = 0;
    exp_cnt  = '0;
    repeat (2) @(posedge clk);
    #3;
    chk("init_locked", 32'(locked), 32'd0);
    chk("init_pulse", 32'(err_pulse), 32'd0);
    chk("init_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;

    // Stuck-at-0 line never locks.
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    reset_dut(1'b1);

    // Clean lock plus 1000 checked bits; the checked-bit window then sits at 40 of 64.
    stream(16 + 1000, -1, -1, 1'b0);

    // Single flips: 4 errors each, loss of lock, re-lock 16 bits later; saturation at 15.
    stream(50, 0, -1, 1'b0);
    stream(50, 0, -1, 1'b0);
    stream(50, 0, -1, 1'b0);
    stream(50, 0, -1, 1'b0);
    // Clear coinciding with a mismatch drops that error from the count.
    stream(50, 0, 0, 1'b0);

    // Mid-CHECK reset, stream continues unbroken and must re-lock cleanly.
    stream(10, -1, -1, 1'b0);
    reset_dut(1'b0);
    stream(40, -1, -1, 1'b0);

    // Alternating rx_valid.
    reset_dut(1'b1);
    stream(60, -1, -1, 1'b1);

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
